// File: rtl/seven_segment_reader.sv
// Captures a multiplexed active-low 7-segment display into per-digit hex nibbles.
// Capture fires 2+STABLE_CYCLES cycles after the pins settle; there is no backpressure.
module seven_segment_reader #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            i_seg,
   input  logic [DIGITS-1:0]     i_dig,
   output logic [4*DIGITS-1:0]   o_data,
   output logic [DIGITS-1:0]     o_valid,
   output logic                  o_update,
   output logic [2:0]            o_index,
   output logic                  o_error
);

   localparam int PW = 7 + DIGITS;

   logic [PW-1:0] sync1;
   logic [PW-1:0] sync2;
   logic [PW-1:0] prev;
   logic [7:0]    count;

   logic          same;
   logic          one_hot;
   logic [2:0]    dig_idx;
   logic          hit;
   logic [3:0]    nibble;
   logic          blank;
   logic          capture;

   always_comb begin
      hit    = 1'b1;
      nibble = 4'h0;
      case (sync2[PW-1:DIGITS])
         7'b0000001: nibble = 4'h0;
         7'b1001111: nibble = 4'h1;
         7'b0010010: nibble = 4'h2;
         7'b0000110: nibble = 4'h3;
         7'b1001100: nibble = 4'h4;
         7'b0100100: nibble = 4'h5;
         7'b0100000: nibble = 4'h6;
         7'b0001111: nibble = 4'h7;
         7'b0000000: nibble = 4'h8;
         7'b0000100: nibble = 4'h9;
         7'b0001000: nibble = 4'hA;
         7'b1100000: nibble = 4'hB;
         7'b0110001: nibble = 4'hC;
         7'b1000010: nibble = 4'hD;
         7'b0110000: nibble = 4'hE;
         7'b0111000: nibble = 4'hF;
         default:    hit    = 1'b0;
      endcase
   end

   always_comb begin
      dig_idx = 3'd0;
      for (int k = 0; k < DIGITS; k++) begin
         if (!sync2[k]) dig_idx = 3'(k);
      end
   end

   assign same    = (sync2 == prev);
   assign one_hot = $onehot(~sync2[DIGITS-1:0]);
   assign blank   = (sync2[PW-1:DIGITS] == 7'h7F);
   // Fires only on the transition into saturation, so a held pattern captures once.
   assign capture = same && (count == 8'(STABLE_CYCLES - 1)) && one_hot;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= '1;
         sync2    <= '1;
         prev     <= '1;
         count    <= 8'd0;
         o_data   <= '0;
         o_valid  <= '0;
         o_update <= 1'b0;
         o_index  <= 3'd0;
         o_error  <= 1'b0;
      end else begin
         sync1    <= {i_seg, i_dig};
         sync2    <= sync1;
         prev     <= sync2;
         o_update <= 1'b0;
         o_error  <= 1'b0;
         if (!same) begin
            count <= 8'd0;
         end else if (count != 8'(STABLE_CYCLES)) begin
            count <= count + 8'd1;
         end
         if (capture) begin
            o_update <= 1'b1;
            o_index  <= dig_idx;
            o_error  <= !hit && !blank;
            for (int k = 0; k < DIGITS; k++) begin
               if (k == int'(dig_idx)) begin
                  o_data[4*k +: 4] <= hit ? nibble : 4'h0;
                  o_valid[k]       <= hit;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader with a pin-history reference model.
module tb_seven_segment_reader;

   localparam int DIGITS = 4;
   localparam int S      = 4;
   localparam int HMAX   = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  i_seg;
   logic [3:0]  i_dig;
   logic [15:0] o_data;
   logic [3:0]  o_valid;
   logic        o_update;
   logic [2:0]  o_index;
   logic        o_error;

   seven_segment_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .i_seg(i_seg), .i_dig(i_dig),
      .o_data(o_data), .o_valid(o_valid), .o_update(o_update),
      .o_index(o_index), .o_error(o_error)
   );

   always #5 clk = ~clk;

   // Segment patterns for hex 0..F, index = nibble value.
   logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   int compared   = 0;
   int mismatched = 0;
   int cyc        = -1;
   int upd_count  = 0;
   int err_count  = 0;

   logic [10:0] hist [HMAX];
   logic        rh   [HMAX];

   logic [15:0] e_data;
   logic [3:0]  e_valid;
   logic        e_upd;
   logic        e_err;
   logic [2:0]  e_idx;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // A capture at edge E needs S+1 identical pin samples ending at E-2, a fresh
   // start (pin change or reset) just before them, no reset since, and one-hot-low dig.
   task automatic model_step(input int e);
      int   w0;
      logic cap;
      logic [3:0] dig;
      logic [6:0] seg;
      int   k;
      logic found;
      logic [3:0] nib;
      e_upd = 1'b0;
      e_err = 1'b0;
      if (rh[e]) begin
         e_data  = '0;
         e_valid = '0;
         e_idx   = '0;
      end else begin
         w0  = e - 2 - S;
         cap = (w0 >= 1);
         if (cap) begin
            for (int j = w0; j <= e; j++) if (rh[j]) cap = 1'b0;
            for (int j = w0; j <= e - 2; j++) if (hist[j] != hist[w0]) cap = 1'b0;
            if (!(rh[w0-1] || hist[w0-1] != hist[w0])) cap = 1'b0;
            dig = hist[w0][3:0];
            if ($countones(~dig) != 1) cap = 1'b0;
         end
         if (cap) begin
            seg = hist[w0][10:4];
            k = 0;
            for (int j = 0; j < DIGITS; j++) if (!dig[j]) k = j;
            found = 1'b0;
            nib   = 4'h0;
            for (int n = 0; n < 16; n++) begin
               if (pat[n] == seg) begin
                  found = 1'b1;
                  nib   = 4'(n);
               end
            end
            e_upd             = 1'b1;
            e_idx             = 3'(k);
            e_data[4*k +: 4]  = nib;
            e_valid[k]        = found;
            e_err             = !found && (seg != 7'h7F);
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (cyc >= HMAX) begin
            $display("FAIL history_overflow: got %0d cycles limit %0d", cyc, HMAX);
            $fatal(1, "history overflow");
         end
         hist[cyc] = {i_seg, i_dig};
         rh[cyc]   = rst;
         model_step(cyc);
         #1;
         check("update", o_update, e_upd);
         check("error", o_error, e_err);
         check("data", o_data, e_data);
         check("valid", o_valid, e_valid);
         if (e_upd || rh[cyc]) check("index", o_index, e_idx);
         if (o_update === 1'b1) upd_count++;
         if (o_error === 1'b1) err_count++;
      end
   end

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   int t0;
   int u0;
   int e0;
   logic [6:0] scan [4] = '{7'b0000110, 7'b1100000, 7'b0110000, 7'b0001111};

   initial begin
      e_data = '0; e_valid = '0; e_idx = '0; e_upd = 1'b0; e_err = 1'b0;
      rst   = 1'b1;
      i_seg = 7'h7F;
      i_dig = 4'hF;
      repeat (3) @(negedge clk);
      check("reset_data", o_data, 16'h0000);
      check("reset_valid", o_valid, 4'h0);
      check("reset_update", o_update, 1'b0);
      check("reset_error", o_error, 1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Digit 0 shows '2': update exactly at T+6.
      i_dig = 4'b1110;
      i_seg = 7'b0010010;
      t0 = cyc + 1;
      wait_cyc(t0 + 5);
      check("s1_no_early_update", o_update, 1'b0);
      @(negedge clk);
      check("s1_update", o_update, 1'b1);
      check("s1_index", o_index, 3'd0);
      check("s1_nibble", o_data[3:0], 4'h2);
      check("s1_valid", o_valid, 4'b0001);
      repeat (2) @(negedge clk);

      // Scan digits 0..3 with 3, b, E, 7.
      u0 = upd_count;
      for (int k = 0; k < 4; k++) begin
         i_dig = ~(4'b0001 << k);
         i_seg = scan[k];
         repeat (8) @(negedge clk);
      end
      check("scan_pulses", upd_count - u0, 4);
      check("scan_data", o_data, 16'h7EB3);
      check("scan_valid", o_valid, 4'hF);

      // Toggling every 3 cycles never qualifies.
      u0 = upd_count;
      for (int i = 0; i < 10; i++) begin
         i_dig = 4'b1110;
         i_seg = (i % 2 == 1) ? pat[1] : pat[4];
         repeat (3) @(negedge clk);
      end
      check("toggle_pulses", upd_count - u0, 0);

      // Blank on digit 1 clears it without an error.
      u0 = upd_count;
      e0 = err_count;
      i_dig = 4'b1101;
      i_seg = 7'h7F;
      repeat (8) @(negedge clk);
      check("blank_nibble", o_data[7:4], 4'h0);
      check("blank_valid1", o_valid[1], 1'b0);
      check("blank_pulses", upd_count - u0, 1);
      check("blank_errors", err_count - e0, 0);

      // Non-hex pattern on digit 3.
      i_dig = 4'b0111;
      i_seg = 7'b1010101;
      t0 = cyc + 1;
      wait_cyc(t0 + 6);
      check("bad_update", o_update, 1'b1);
      check("bad_error", o_error, 1'b1);
      check("bad_index", o_index, 3'd3);
      check("bad_valid3", o_valid[3], 1'b0);
      repeat (2) @(negedge clk);

      // Two active digit lines: nothing changes.
      u0 = upd_count;
      i_dig = 4'b1100;
      i_seg = pat[5];
      repeat (10) @(negedge clk);
      check("multi_pulses", upd_count - u0, 0);
      check("multi_data", o_data, 16'h0E03);
      check("multi_valid", o_valid, 4'b0101);

      // Reset at count 2 aborts; requalification takes the full 6 cycles.
      i_dig = 4'b1110;
      i_seg = pat[5];
      t0 = cyc + 1;
      wait_cyc(t0 + 4);
      rst = 1'b1;
      @(negedge clk);
      check("rst_data", o_data, 16'h0000);
      check("rst_valid", o_valid, 4'h0);
      check("rst_update", o_update, 1'b0);
      check("rst_index", o_index, 3'd0);
      check("rst_error", o_error, 1'b0);
      rst = 1'b0;
      u0 = upd_count;
      t0 = cyc + 1;
      wait_cyc(t0 + 5);
      check("rst_no_early", upd_count - u0, 0);
      @(negedge clk);
      check("rst_update_t6", o_update, 1'b1);
      check("rst_nibble", o_data[3:0], 4'h5);
      check("rst_valid_after", o_valid, 4'b0001);
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
